nibble_sub_seq: RTL

Multi-precision subtract sequencer: computes diff = a - b - bin on WIDTH-bit operands using one 4-bit full-subtractor slice, one nibble per cycle, LSB nibble first. The borrow is chained between cycles through a register. Valid/ready handshakes on both the command side and the result side. Sits between an operand source and a result consumer wherever wide subtracts are needed but only nibble-wide subtract hardware is budgeted.

---
 rtl/nibble_sub_seq.sv | 84 ++++++++
 1 files changed

// File: rtl/nibble_sub_seq.sv
// nibble_sub_seq: nibble-serial WIDTH-bit subtractor (diff = a - b - bin); define SUB_SAT_EN for unsigned saturation
module nibble_sub_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int NIB = WIDTH / 4;
    localparam int CW = NIB > 1 ? $clog2(NIB) : 1;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] opa, opb, diff_nx;
    logic [CW-1:0] cnt;
    logic [3:0] d;
    logic brw, c, last;
    assign start_ready = state == IDLE;
    assign res_valid = state == DONE;
    assign last = cnt == CW'(NIB - 1);
    // c ends up as the borrow out of the nibble slice
    always_comb begin
        d = '0;
        c = brw;
        for (int i = 0; i < 4; i++) begin
            d[i] = opa[i] ^ opb[i] ^ c;
            c = (~opa[i] & opb[i]) | (~(opa[i] ^ opb[i]) & c);
        end
    end
    always_comb begin
        diff_nx = diff;
        diff_nx[{cnt, 2'b00} +: 4] = d;
    end
    always_comb begin
        state_nx = state;
        state_nx = state == IDLE ? (start_valid ? RUN : IDLE) :
                   state == RUN  ? (last ? DONE : RUN) :
                                   (res_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            opa <= '0;
            opb <= '0;
            brw <= 1'b0;
            cnt <= '0;
            diff <= '0;
            bout <= 1'b0;
            zero <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start_valid) begin
                opa <= a;
                opb <= b;
                brw <= bin;
                cnt <= '0;
            end
            if (state == RUN) begin
                opa <= opa >> 4;
                opb <= opb >> 4;
                brw <= c;
                cnt <= cnt + 1'b1;
                diff <= diff_nx;
                if (last) begin
                    bout <= c;
`ifdef SUB_SAT_EN
                    diff <= c ? '0 : diff_nx;
                    zero <= c | (diff_nx == '0);
`else
                    zero <= diff_nx == '0;
`endif
                end
            end
        end
    end
endmodule
